// File: rtl/y1234_preimage_search.sv
// Sequential inverse of the y1234 lab function: sweeps abc = 0..7 one per clock
// and reports which candidates reproduce the latched 4-bit target pattern.
module y1234_preimage_search #(
  parameter bit FIRST_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] target,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [0:2] abc_out,
  output logic [7:0] match_mask,
  output logic [3:0] match_count
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cand_q, cand_d;
  logic [3:0] tgt_q, tgt_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] count_q, count_d;
  logic       found_q, found_d;
  logic [2:0] abc_q, abc_d;

  logic       a, b, c, hit;
  logic [3:0] y;

  // Lab function evaluated on the current candidate, a is the MSB of cand.
  always_comb begin
    a   = cand_q[2];
    b   = cand_q[1];
    c   = cand_q[0];
    y   = {1'b0,
           a & ~b & c,
           (~a & b & c) | (a & b & c),
           (~a & ~b & ~c) | (a & b & c)};
    hit = (y == tgt_q);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    tgt_d   = tgt_q;
    mask_d  = mask_q;
    count_d = count_q;
    found_d = found_q;
    abc_d   = abc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          tgt_d   = target;
          mask_d  = 8'h00;
          count_d = 4'd0;
          found_d = 1'b0;
          abc_d   = 3'd0;
          cand_d  = 3'd0;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (hit) begin
          mask_d[cand_q] = 1'b1;
          count_d        = count_q + 4'd1;
          if (!found_q) begin
            abc_d   = cand_q;
            found_d = 1'b1;
          end
        end
        if (cand_q == 3'd7 || (FIRST_ONLY && hit)) state_d = DONE;
        else cand_d = cand_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= 3'd0;
      tgt_q   <= 4'd0;
      mask_q  <= 8'h00;
      count_q <= 4'd0;
      found_q <= 1'b0;
      abc_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      tgt_q   <= tgt_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      found_q <= found_d;
      abc_q   <= abc_d;
    end
  end

  // DONE always lasts exactly one cycle, so the state decode is the pulse.
  assign busy        = (state_q == SEARCH);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign abc_out     = abc_q;
  assign match_mask  = mask_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_y1234_preimage_search.sv
// Bench for y1234_preimage_search: table vectors, random targets against a
// lookup-table reference model, and hand-written reset/busy/back-to-back cases.
module tb_y1234_preimage_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [3:0] target;
  logic       busy0, done0, found0, busy1, done1, found1;
  logic [0:2] abc0, abc1;
  logic [7:0] mask0, mask1;
  logic [3:0] cnt0, cnt1;

  logic       sel;
  logic       busy_s, done_s, found_s;
  logic [2:0] abc_s;
  logic [7:0] mask_s;
  logic [3:0] cnt_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  y1234_preimage_search #(.FIRST_ONLY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .target(target),
    .busy(busy0), .done(done0), .found(found0), .abc_out(abc0),
    .match_mask(mask0), .match_count(cnt0));

  y1234_preimage_search #(.FIRST_ONLY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .target(target),
    .busy(busy1), .done(done1), .found(found1), .abc_out(abc1),
    .match_mask(mask1), .match_count(cnt1));

  assign busy_s  = sel ? busy1  : busy0;
  assign done_s  = sel ? done1  : done0;
  assign found_s = sel ? found1 : found0;
  assign abc_s   = sel ? abc1   : abc0;
  assign mask_s  = sel ? mask1  : mask0;
  assign cnt_s   = sel ? cnt1   : cnt0;

  typedef struct packed {
    logic       fo;
    logic [3:0] tgt;
    logic [7:0] mask;
    logic [3:0] count;
    logic [2:0] abc;
    logic       found;
    logic [3:0] lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: y pattern per candidate straight from the truth table.
  function automatic void model(input logic fo, input logic [3:0] tgt,
                                output logic [7:0] mask, output logic [3:0] count,
                                output logic [2:0] abc, output logic found,
                                output int lat);
    logic [3:0] ytab [8];
    ytab  = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0011};
    mask  = 8'h00; count = 4'd0; abc = 3'd0; found = 1'b0; lat = 8;
    for (int k = 0; k < 8; k++) begin
      if (ytab[k] == tgt) begin
        mask  = mask | (8'h01 << k);
        count = count + 4'd1;
        if (!found) begin
          found = 1'b1;
          abc   = 3'(k);
        end
        if (fo) begin
          lat = k + 1;
          break;
        end
      end
    end
  endfunction

  task automatic do_start(input logic fo, input logic [3:0] tgt);
    @(negedge clk);
    sel    = fo;
    target = tgt;
    if (fo) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_s && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_s) check("done_timeout", 0, 1);
  endtask

  task automatic sweep(input string name, input logic fo, input logic [3:0] tgt,
                       input logic [7:0] emask, input logic [3:0] ecnt,
                       input logic [2:0] eabc, input logic efound, input int elat);
    int lat;
    do_start(fo, tgt);
    check({name, "_busy"}, int'(busy_s), 1);
    wait_done(lat);
    check({name, "_lat"},   lat, elat);
    check({name, "_idle"},  int'(busy_s), 0);
    check({name, "_found"}, int'(found_s), int'(efound));
    check({name, "_abc"},   int'(abc_s), int'(eabc));
    check({name, "_mask"},  int'(mask_s), int'(emask));
    check({name, "_count"}, int'(cnt_s), int'(ecnt));
    @(posedge clk); #1;
    check({name, "_pulse"}, int'(done_s), 0);
    check({name, "_hold"},  int'(mask_s), int'(emask));
  endtask

  initial begin
    int lat, dcount;
    logic [7:0] m; logic [3:0] cn; logic [2:0] ab; logic fd; int el;
    logic fo; logic [3:0] tg;

    vecs[0] = '{1'b0, 4'h1, 8'h01, 4'd1, 3'd0, 1'b1, 4'd8};
    vecs[1] = '{1'b0, 4'h0, 8'h56, 4'd4, 3'd1, 1'b1, 4'd8};
    vecs[2] = '{1'b0, 4'h3, 8'h80, 4'd1, 3'd7, 1'b1, 4'd8};
    vecs[3] = '{1'b0, 4'h4, 8'h20, 4'd1, 3'd5, 1'b1, 4'd8};
    vecs[4] = '{1'b0, 4'h8, 8'h00, 4'd0, 3'd0, 1'b0, 4'd8};
    vecs[5] = '{1'b1, 4'h0, 8'h02, 4'd1, 3'd1, 1'b1, 4'd2};
    vecs[6] = '{1'b1, 4'h3, 8'h80, 4'd1, 3'd7, 1'b1, 4'd8};
    vecs[7] = '{1'b1, 4'h8, 8'h00, 4'd0, 3'd0, 1'b0, 4'd8};

    sel = 1'b0; rst = 1'b1; start0 = 1'b0; start1 = 1'b0; target = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  int'(busy0 | busy1), 0);
    check("rst_done",  int'(done0 | done1), 0);
    check("rst_found", int'(found0 | found1), 0);
    check("rst_abc",   int'(abc0 | abc1), 0);
    check("rst_mask",  int'(mask0 | mask1), 0);
    check("rst_count", int'(cnt0 | cnt1), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++)
      sweep($sformatf("vec%0d", i), vecs[i].fo, vecs[i].tgt, vecs[i].mask,
            vecs[i].count, vecs[i].abc, vecs[i].found, int'(vecs[i].lat));

    for (int i = 0; i < 16; i++) begin
      fo = 1'($urandom_range(0, 1));
      tg = 4'($urandom_range(0, 15));
      model(fo, tg, m, cn, ab, fd, el);
      sweep($sformatf("rnd%0d_fo%0d_t%0h", i, fo, tg), fo, tg, m, cn, ab, fd, el);
    end

    // start while busy is ignored, including its new target
    do_start(1'b0, 4'h1);
    @(negedge clk); target = 4'h4; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    wait_done(lat);
    check("ign_lat",  lat + 1, 8);
    check("ign_mask", int'(mask0), 8'h01);
    check("ign_abc",  int'(abc0), 0);

    // back-to-back start accepted in DONE
    @(negedge clk); target = 4'h3; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    check("b2b_busy", int'(busy0), 1);
    check("b2b_done", int'(done0), 0);
    wait_done(lat);
    check("b2b_lat",   lat, 8);
    check("b2b_mask",  int'(mask0), 8'h80);
    check("b2b_count", int'(cnt0), 1);

    // reset mid-sweep with cand=3: everything clears, no done follows
    do_start(1'b0, 4'h2);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy",  int'(busy0), 0);
    check("mrst_done",  int'(done0), 0);
    check("mrst_found", int'(found0), 0);
    check("mrst_abc",   int'(abc0), 0);
    check("mrst_mask",  int'(mask0), 0);
    check("mrst_count", int'(cnt0), 0);
    @(negedge clk); rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0 || busy0) dcount++;
    end
    check("mrst_quiet", dcount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
